// File: rtl/spi_master_param.sv
// -----------------------------------------------------------------------------
// spi_master_param
//
// Parametrised SPI master with a ready/valid command handshake. Each accepted
// command shifts one DATA_W-bit word out on mosi. At the same time it captures
// DATA_W bits from miso. SPI mode (cpol/cpha) is chosen per transfer. SCLK is
// gated: it only toggles while cs is low.
//
// Sequence: IDLE -> SETUP -> XFER -> HOLD -> IDLE.
//   SETUP : CLK_DIV cycles with cs low and sclk at its idle level.
//   XFER  : 2*DATA_W sclk toggles, one every CLK_DIV cycles.
//   HOLD  : CLK_DIV cycles before cs rises. done pulses on that same edge.
//
// Parameters
//   DATA_W    bits per transfer (>= 2)
//   CLK_DIV   clk cycles per SCLK half-period (>= 1)
//   LSB_FIRST 1 = bit 0 first on both mosi and miso, 0 = MSB first
//
// Ports
//   clk, rst_n  system clock, asynchronous active-low reset
//   newd/ready  command valid / block can accept a command
//   din         transmit word, sampled at accept
//   cpol, cpha  SPI mode, sampled at accept (cpol also drives idle sclk)
//   miso        serial data from the slave, synchronous to clk
//   sclk, cs    serial clock (registered) and active-low chip select
//   mosi        serial data to the slave
//   dout        received word, updated together with done
//   done        one-cycle pulse at the end of a transfer
//   busy        high from accept until cs rises
// -----------------------------------------------------------------------------
module spi_master_param #(
    parameter int DATA_W    = 12,
    parameter int CLK_DIV   = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              newd,
    output logic              ready,
    input  logic [DATA_W-1:0] din,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              miso,
    output logic              sclk,
    output logic              cs,
    output logic              mosi,
    output logic [DATA_W-1:0] dout,
    output logic              done,
    output logic              busy
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_W + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [EDGE_W-1:0]   edge_q, edge_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                cpol_q, cpol_d;
    logic                cpha_q, cpha_d;
    logic                sclk_q, sclk_d;
    logic                cs_q, cs_d;
    logic                mosi_q, mosi_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                div_wrap;
    logic [EDGE_W-1:0]   edge_num;
    logic                sample_edge;
    logic                shift_edge;
    logic [DATA_W-1:0]   tx_rot;
    logic [DATA_W-1:0]   rx_shifted;
    logic                din_first;
    logic                tx_next_bit;

    // Bit order. The transmit word is rotated rather than shifted, so the
    // bit at the output end of tx_q is always the one on mosi next.
    if (LSB_FIRST) begin : g_lsb
        assign tx_rot      = {tx_q[0], tx_q[DATA_W-1:1]};
        assign rx_shifted  = {miso, rx_q[DATA_W-1:1]};
        assign din_first   = din[0];
        assign tx_next_bit = tx_rot[0];
    end else begin : g_msb
        assign tx_rot      = {tx_q[DATA_W-2:0], tx_q[DATA_W-1]};
        assign rx_shifted  = {rx_q[DATA_W-2:0], miso};
        assign din_first   = din[DATA_W-1];
        assign tx_next_bit = tx_rot[DATA_W-1];
    end

    assign div_wrap = (div_q == DIV_LAST);
    assign edge_num = edge_q + EDGE_W'(1);
    // Odd edges are leading edges. cpha=0 samples on leading edges and
    // cpha=1 samples on trailing edges. mosi moves on the other edge type,
    // except on edge 1 (cpha=1: first bit already out) and edge 2W (the
    // transfer is over).
    assign sample_edge = edge_num[0] ^ cpha_q;
    assign shift_edge  = !sample_edge && (edge_num != EDGE_W'(1)) && (edge_num != EDGE_LAST);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        edge_d  = edge_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        dout_d  = dout_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        sclk_d  = sclk_q;
        cs_d    = cs_q;
        mosi_d  = mosi_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // sclk follows cpol while idle, so it is already at the right
                // idle level when cs falls.
                sclk_d  = cpol;
                cs_d    = 1'b1;
                mosi_d  = 1'b0;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                if (newd && ready_q) begin
                    tx_d    = din;
                    rx_d    = '0;
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    cs_d    = 1'b0;
                    mosi_d  = din_first;
                    div_d   = '0;
                    edge_d  = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                sclk_d = cpol_q;
                if (div_wrap) begin
                    div_d   = '0;
                    state_d = XFER;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            XFER: begin
                if (div_wrap) begin
                    div_d  = '0;
                    edge_d = edge_num;
                    sclk_d = ~sclk_q;
                    if (sample_edge) begin
                        rx_d = rx_shifted;
                    end
                    if (shift_edge) begin
                        tx_d   = tx_rot;
                        mosi_d = tx_next_bit;
                    end
                    if (edge_num == EDGE_LAST) begin
                        state_d = HOLD;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            HOLD: begin
                sclk_d = cpol_q;
                if (div_wrap) begin
                    div_d   = '0;
                    cs_d    = 1'b1;
                    mosi_d  = 1'b0;
                    dout_d  = rx_q;
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            edge_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            dout_q  <= '0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            sclk_q  <= 1'b0;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            edge_q  <= edge_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            sclk_q  <= sclk_d;
            cs_q    <= cs_d;
            mosi_q  <= mosi_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ready = ready_q;
    assign sclk  = sclk_q;
    assign cs    = cs_q;
    assign mosi  = mosi_q;
    assign dout  = dout_q;
    assign done  = done_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_spi_master_param.sv
// -----------------------------------------------------------------------------
// tb_spi_master_param
//
// Three DUT configurations run side by side:
//   cfg0: DATA_W=12, CLK_DIV=4, LSB first  (defaults, mode-0 loopback)
//   cfg1: DATA_W=8,  CLK_DIV=2, MSB first  (mode 3)
//   cfg2: DATA_W=4,  CLK_DIV=1, LSB first  (modes 1 and 2)
// Each configuration has its own stimulus process and its own SPI slave
// model. The slave drives miso on its launch edges and records mosi on its
// capture edges. At every accept, the expected mosi word, dout and accept
// cycle go into a queue. A separate monitor pops and compares when done
// pulses.
// -----------------------------------------------------------------------------
module tb_spi_master_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit fin [3];

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
        localparam int W   = (gi == 0) ? 12 : (gi == 1) ? 8 : 4;
        localparam int DIV = (gi == 0) ? 4 : (gi == 1) ? 2 : 1;
        localparam bit LSB = (gi != 1);
        localparam int LIM = 4 * (2 * W + 2) * DIV + 50;

        // Two directed transfers per configuration.
        localparam int D_DIN0  = (gi == 0) ? 'hA5C : (gi == 1) ? 'h96 : 'h9;
        localparam int D_SLV0  = (gi == 0) ? 'h000 : (gi == 1) ? 'h3C : 'h6;
        localparam bit D_POL0  = (gi == 1);
        localparam bit D_PHA0  = (gi != 0);
        localparam bit D_LOOP0 = (gi == 0);
        localparam int D_DIN1  = (gi == 0) ? 'h3A6 : (gi == 1) ? 'h5A : 'h3;
        localparam int D_SLV1  = (gi == 0) ? 'h5C3 : (gi == 1) ? 'hC3 : 'hA;
        localparam bit D_POL1  = (gi == 2);

        logic         rst_n;
        logic         newd;
        logic         ready;
        logic [W-1:0] din;
        logic         cpol;
        logic         cpha;
        logic         miso;
        logic         sclk;
        logic         cs;
        logic         mosi;
        logic [W-1:0] dout;
        logic         done;
        logic         busy;
        logic         loop_en = 1'b0;
        logic         slave_miso = 1'b0;
        logic [W-1:0] slave_word_in = '0;

        assign miso = loop_en ? mosi : slave_miso;

        spi_master_param #(
            .DATA_W   (W),
            .CLK_DIV  (DIV),
            .LSB_FIRST(LSB)
        ) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .newd (newd),
            .ready(ready),
            .din  (din),
            .cpol (cpol),
            .cpha (cpha),
            .miso (miso),
            .sclk (sclk),
            .cs   (cs),
            .mosi (mosi),
            .dout (dout),
            .done (done),
            .busy (busy)
        );

        // Scoreboard queues: expected mosi word, expected dout, accept cycle.
        logic [W-1:0] q_tx [$];
        logic [W-1:0] q_rx [$];
        int           q_t0 [$];

        int           cyc = 0;
        int           acc_cnt = 0;
        int           acc_cyc = 0;
        bit           cur_cpol = 1'b0;
        bit           cur_cpha = 1'b0;
        logic [W-1:0] cur_slave = '0;

        // Position of the k-th serial bit inside a word.
        function automatic int bidx(input int k);
            return LSB ? k : (W - 1 - k);
        endfunction

        function automatic string nm(input string s);
            return $sformatf("cfg%0d_%s", gi, s);
        endfunction

        // Accept detector: an accept is newd && ready seen at a rising edge.
        initial forever begin
            @(posedge clk);
            cyc++;
            if (rst_n && newd && ready) begin
                q_tx.push_back(din);
                q_rx.push_back(loop_en ? din : slave_word_in);
                q_t0.push_back(cyc);
                cur_cpol  = cpol;
                cur_cpha  = cpha;
                cur_slave = slave_word_in;
                acc_cnt++;
                acc_cyc   = cyc;
            end
        end

        // Slave model, protocol observer and scoreboard monitor (falling edge).
        logic         p_cs = 1'b1;
        logic         p_sclk = 1'b0;
        logic         p_mosi = 1'b0;
        logic         p_done = 1'b0;
        int           edge_n = 0;
        int           sh_n = 0;
        int           rx_n = 0;
        int           viol = 0;
        int           terr = 0;
        int           t_start = 0;
        int           last_done_cyc = -100;
        logic [W-1:0] s_rx = '0;

        initial forever begin : mon
            logic [W-1:0] e_tx;
            logic [W-1:0] e_rx;
            int           e_t0;
            bit           smp;
            @(negedge clk);
            if (p_cs && !cs) begin
                edge_n  = 0;
                sh_n    = 0;
                rx_n    = 0;
                viol    = 0;
                terr    = 0;
                s_rx    = '0;
                t_start = acc_cyc;
                chk(nm("busy_at_cs_fall"), int'(busy), 1);
                chk(nm("sclk_idle_at_cs_fall"), int'(sclk), int'(cur_cpol));
                if (!cur_cpha) begin
                    slave_miso = cur_slave[bidx(0)];
                    sh_n = 1;
                end
            end else if (!p_cs && !cs) begin
                if (sclk != p_sclk) begin
                    edge_n++;
                    if (cyc != t_start + (edge_n + 1) * DIV) terr++;
                    smp = ((edge_n % 2) == 1) ^ cur_cpha;
                    if (smp) begin
                        if (mosi != p_mosi) viol++;
                        if (rx_n < W) s_rx[bidx(rx_n)] = p_mosi;
                        rx_n++;
                    end else if (sh_n < W) begin
                        slave_miso = cur_slave[bidx(sh_n)];
                        sh_n++;
                    end
                end else if (mosi != p_mosi) begin
                    viol++;
                end
            end
            if ((cs != p_cs) && (sclk != p_sclk)) viol++;
            if (done) begin
                chk(nm("done_one_cycle"), int'(p_done), 0);
                chk(nm("done_expected"), int'(q_tx.size() != 0), 1);
                if (q_tx.size() != 0) begin
                    e_tx = q_tx.pop_front();
                    e_rx = q_rx.pop_front();
                    e_t0 = q_t0.pop_front();
                    chk(nm("dout"), int'(dout), int'(e_rx));
                    chk(nm("mosi_word"), int'(s_rx), int'(e_tx));
                    chk(nm("done_cycle"), cyc, e_t0 + (2 * W + 2) * DIV);
                    chk(nm("sclk_edges"), edge_n, 2 * W);
                    chk(nm("edge_timing_errors"), terr, 0);
                    chk(nm("protocol_violations"), viol, 0);
                    chk(nm("cs_high_at_done"), int'(cs), 1);
                    chk(nm("ready_at_done"), int'(ready), 1);
                    chk(nm("busy_at_done"), int'(busy), 0);
                    last_done_cyc = cyc;
                    $display("[TB] cfg%0d xfer mode=%0d tx=%h dout=%h slave_rx=%h t0=%0d done=%0d",
                             gi, {cur_cpol, cur_cpha}, e_tx, dout, s_rx, e_t0, cyc);
                end
            end
            p_cs   = cs;
            p_sclk = sclk;
            p_mosi = mosi;
            p_done = done;
        end

        task automatic check_rst(input string tag);
            chk(nm({tag, "_sclk"}), int'(sclk), 0);
            chk(nm({tag, "_cs"}), int'(cs), 1);
            chk(nm({tag, "_mosi"}), int'(mosi), 0);
            chk(nm({tag, "_ready"}), int'(ready), 1);
            chk(nm({tag, "_busy"}), int'(busy), 0);
            chk(nm({tag, "_done"}), int'(done), 0);
            chk(nm({tag, "_dout"}), int'(dout), 0);
        endtask

        task automatic wait_idle();
            int n;
            n = 0;
            while ((q_tx.size() != 0 || busy) && n < LIM) begin
                @(negedge clk);
                n++;
            end
            chk(nm("idle_within_bound"), int'(n < LIM), 1);
        endtask

        task automatic xfer(input logic [W-1:0] d, input logic [W-1:0] s,
                            input bit pol, input bit pha, input bit lp);
            int n;
            int a0;
            wait_idle();
            cpol = pol;
            cpha = pha;
            loop_en = lp;
            slave_word_in = s;
            @(negedge clk);
            din  = d;
            newd = 1'b1;
            a0   = acc_cnt;
            n    = 0;
            do begin
                @(negedge clk);
                n++;
            end while (acc_cnt == a0 && n < LIM);
            newd = 1'b0;
            din  = W'($urandom);
            chk(nm("accept_seen"), int'(acc_cnt != a0), 1);
        endtask

        initial begin : drv
            int n;
            int a0;
            rst_n = 1'b0;
            newd  = 1'b0;
            din   = '0;
            cpol  = 1'b0;
            cpha  = 1'b0;
            repeat (3) @(negedge clk);
            check_rst("reset");
            rst_n = 1'b1;
            @(negedge clk);

            xfer(W'(D_DIN0), W'(D_SLV0), D_POL0, D_PHA0, D_LOOP0);
            wait_idle();
            @(negedge clk);
            chk(nm("idle_sclk_level"), int'(sclk), int'(D_POL0));
            xfer(W'(D_DIN1), W'(D_SLV1), D_POL1, 1'b0, 1'b0);

            for (int i = 0; i < 6; i++) begin
                xfer(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            end

            // Back-to-back: newd held high, din scrambled every cycle.
            wait_idle();
            cpol = 1'($urandom);
            cpha = 1'($urandom);
            loop_en = 1'b0;
            slave_word_in = W'($urandom);
            @(negedge clk);
            din  = W'($urandom);
            newd = 1'b1;
            a0   = acc_cnt;
            n    = 0;
            do begin
                @(negedge clk);
                din = W'($urandom);
                slave_word_in = W'($urandom);
                n++;
            end while (acc_cnt < a0 + 2 && n < 3 * LIM);
            newd = 1'b0;
            chk(nm("b2b_two_accepts"), acc_cnt - a0, 2);
            chk(nm("b2b_gap"), acc_cyc, last_done_cyc + 1);

            // Reset in the middle of a transfer, right after SCLK edge 7.
            xfer(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            n = 0;
            do begin
                @(negedge clk);
                #1;
                n++;
            end while (edge_n < 7 && n < LIM);
            chk(nm("edge7_reached"), int'(edge_n >= 7), 1);
            #1;
            rst_n = 1'b0;
            #1;
            check_rst("midreset");
            q_tx.delete();
            q_rx.delete();
            q_t0.delete();
            repeat (3) @(negedge clk);
            chk(nm("no_done_in_reset"), int'(done), 0);
            rst_n = 1'b1;

            xfer(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            wait_idle();
            repeat (2) @(negedge clk);
            fin[gi] = 1'b1;
        end
    end

    initial begin : main
        int c;
        c = 0;
        while (!(fin[0] && fin[1] && fin[2]) && c < 50000) begin
            @(posedge clk);
            c++;
        end
        chk("all_configs_finished", int'(fin[0] && fin[1] && fin[2]), 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_master_param.md
# spi_master_param

Parametrised SPI master: the next generation of the team's 12-bit transmit-only serialiser. It adds configurable word width, an SCLK divider, bit order, all four SPI modes selected per transfer, full-duplex MISO capture, and a ready/valid command handshake. It sits between a register or stream front-end and an off-chip SPI slave. SCLK is gated and toggles only during a transfer.

## Interface
Parameters:
- DATA_W, 12, bits per transfer (≥2)
- CLK_DIV, 4, clk cycles per SCLK half-period (≥1)
- LSB_FIRST, 1, 1 = bit 0 shifted first; 0 = bit DATA_W-1 first; applies to both MOSI and MISO

Ports:
- clk  in  1  system clock; all logic is on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- newd  in  1  command valid
- ready  out  1  block can accept a command
- din  in  DATA_W  transmit word, sampled at accept
- cpol  in  1  SCLK idle level; sampled at accept
- cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; sampled at accept
- miso  in  1  serial data from the slave; synchronous to clk
- sclk  out  1  registered serial clock
- cs  out  1  active-low chip select
- mosi  out  1  serial data to the slave
- dout  out  DATA_W  received word; updated at done and held until the next done
- done  out  1  one-cycle pulse at the end of a transfer
- busy  out  1  high from accept until cs rises

## Operation
- Reset values: sclk=0, cs=1, mosi=0, ready=1, busy=0, done=0, dout=0, state IDLE, counters 0.
- Reset is asynchronous at any point. Mid-transfer it aborts immediately with no done pulse; dout keeps 0.
- States: IDLE → SETUP → XFER → HOLD → IDLE.
- IDLE
  - ready=1, cs=1, mosi=0.
  - sclk <= cpol every cycle, so cpol must be stable ≥1 cycle before newd.
- Accept occurs on a clk edge with newd=1 and ready=1. At that edge:
  - latch din, cpol and cpha;
  - ready<=0, busy<=1, cs<=0;
  - mosi <= first bit (din[0] if LSB_FIRST, else din[DATA_W-1]);
  - go to SETUP.
- newd while ready=0 is ignored; no queuing.
- SETUP: CLK_DIV cycles with cs low and sclk at idle level, then XFER.
- XFER
  - An edge counter issues 2·DATA_W SCLK toggles, one every CLK_DIV clk cycles.
  - Odd-numbered edges (1, 3, …) are leading edges; even-numbered edges are trailing edges.
  - cpha=0: miso is sampled on edges 1, 3, …, 2W−1. mosi advances to the next bit on edges 2, 4, …, 2W−2.
  - cpha=1: mosi advances on edges 3, 5, …, 2W−1. miso is sampled on edges 2, 4, …, 2W.
  - Sampling captures the miso value present at the clk edge that toggles sclk.
  - Sampled bits fill the receive shift register in the same order as transmit.
  - After edge 2W, sclk is back at cpol; go to HOLD.
- HOLD
  - CLK_DIV cycles with cs low and mosi holding the last bit.
  - At the final HOLD edge: cs<=1, mosi<=0, dout<=rx shift register, done<=1, ready<=1, busy<=0; go to IDLE.

## Timing
- Accept at clk edge T0.
- cs falls after T0.
- SCLK edge k (k = 1..2W) occurs at T0 + (k+1)·CLK_DIV.
- cs rises and done pulses at T0 + (2W+2)·CLK_DIV. Defaults give 104 cycles.
- Earliest next accept is the following clk edge, i.e. one idle cycle with cs=1 between transfers.
- sclk never toggles while cs=1.
- cs never changes on the same clk edge as an sclk toggle.
- done is high for exactly one cycle per completed transfer.

## Test plan
- Reset state: hold rst_n=0 → sclk=0, cs=1, mosi=0, ready=1, busy=0, done=0, dout=0.
- Defaults, mode 0, loopback: cpol=0, cpha=0, din=12'hA5C, miso tied to mosi.
  - mosi bits LSB first: 0,0,1,1,1,0,1,0,0,1,0,1.
  - 24 sclk toggles.
  - done at T0+104; dout=12'hA5C.
- Mode 3, MSB first: LSB_FIRST=0, DATA_W=8, CLK_DIV=2, cpol=1, cpha=1, din=8'h96.
  - Slave model drives 8'h3C, shifting on leading edges.
  - sclk idles high; mosi changes only on leading edges.
  - dout=8'h3C; cs rises at T0+36.
- Mode 1 and mode 2 with CLK_DIV=1, DATA_W=4:
  - Check the sample edges against a reference slave model.
  - Check the SCLK edge spacing is exactly 1 cycle.
- Busy and back-to-back:
  - Hold newd=1 through the whole transfer, with din changing mid-transfer.
  - Only the latched din is sent.
  - The second transfer starts exactly 1 cycle after done, with a 1-cycle cs high gap.
- Reset mid-transfer:
  - Assert rst_n=0 after SCLK edge 7.
  - Outputs are at reset values immediately, with no done pulse.
  - The next transfer after release completes correctly.
